// File: rtl/mem_access_unit.sv
// Memory-access stage: byte-serial loads/stores on an 8-bit synchronous RAM port.
// Optional misaligned-access trap enabled by defining MEMACC_MISALIGN_TRAP_EN.

`ifndef MEM_ACCESS_UNIT_OPS
`define MEM_ACCESS_UNIT_OPS
`define AluOpBus   7:0
`define ALU_NOP_OP 8'h00
`define ALU_ADD_OP 8'h20
`define ALU_LB_OP  8'he0
`define ALU_LH_OP  8'he1
`define ALU_LW_OP  8'he3
`define ALU_LBU_OP 8'he4
`define ALU_LHU_OP 8'he5
`define ALU_SB_OP  8'he8
`define ALU_SH_OP  8'he9
`define ALU_SW_OP  8'heb
`endif

module mem_access_unit #(
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [`AluOpBus]  aluop_i,
   input  logic              wreg_i,
   input  logic [4:0]        waddr_i,
   input  logic [31:0]       alurslt_i,
   input  logic [31:0]       sdata_i,
   input  logic [7:0]        mem_din,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   output logic              stall_req_o,
   output logic              wreg_o,
   output logic [4:0]        waddr_o,
   output logic [31:0]       wdata_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state, state_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic [`AluOpBus]  op;
   logic [31:0]       addr, sdata, ldata;
   logic [4:0]        waddr;
   logic              wreg;

   function automatic logic is_load(input logic [`AluOpBus] o);
      return (o == `ALU_LB_OP) || (o == `ALU_LH_OP) || (o == `ALU_LW_OP) ||
             (o == `ALU_LBU_OP) || (o == `ALU_LHU_OP);
   endfunction

   function automatic logic is_store(input logic [`AluOpBus] o);
      return (o == `ALU_SB_OP) || (o == `ALU_SH_OP) || (o == `ALU_SW_OP);
   endfunction

   function automatic logic [2:0] op_size(input logic [`AluOpBus] o);
      case (o)
         `ALU_LB_OP, `ALU_LBU_OP, `ALU_SB_OP: return 3'd1;
         `ALU_LH_OP, `ALU_LHU_OP, `ALU_SH_OP: return 3'd2;
         default:                             return 3'd4;
      endcase
   endfunction

   logic       in_load, in_store, in_mis;
   logic [2:0] in_size, size;

   assign in_load  = is_load(aluop_i);
   assign in_store = is_store(aluop_i);
   assign in_size  = op_size(aluop_i);
   assign size     = op_size(op);

`ifdef MEMACC_MISALIGN_TRAP_EN
   assign in_mis = (in_load || in_store) &&
                   (((in_size == 3'd2) && alurslt_i[0]) ||
                    ((in_size == 3'd4) && (alurslt_i[1:0] != 2'b00)));
`else
   assign in_mis = 1'b0;
`endif

   // 32-bit modulo add, then wrap into the RAM address space
   logic [ADDR_W-1:0] addr_k;
   assign addr_k = ADDR_W'(addr + {29'd0, cnt});

   logic [7:0] sbyte;
   always_comb begin
      case (cnt[1:0])
         2'd0:    sbyte = sdata[7:0];
         2'd1:    sbyte = sdata[15:8];
         2'd2:    sbyte = sdata[23:16];
         default: sbyte = sdata[31:24];
      endcase
   end

   logic [31:0] ldata_ext;
   always_comb begin
      case (op)
         `ALU_LB_OP:  ldata_ext = {{24{ldata[7]}}, ldata[7:0]};
         `ALU_LBU_OP: ldata_ext = {24'd0, ldata[7:0]};
         `ALU_LH_OP:  ldata_ext = {{16{ldata[15]}}, ldata[15:0]};
         `ALU_LHU_OP: ldata_ext = {16'd0, ldata[15:0]};
         default:     ldata_ext = ldata;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      mem_a       = '0;
      mem_dout    = '0;
      mem_wr      = 1'b0;
      stall_req_o = 1'b0;
      wreg_o      = 1'b0;
      waddr_o     = '0;
      wdata_o     = '0;
      misalign_o  = 1'b0;
      case (state)
         IDLE: begin
            if (in_mis) begin
               misalign_o = 1'b1;
            end else if (in_load) begin
               mem_a       = alurslt_i[ADDR_W-1:0];
               stall_req_o = 1'b1;
               state_nxt   = RD;
               cnt_nxt     = 3'd1;
            end else if (in_store) begin
               mem_a       = alurslt_i[ADDR_W-1:0];
               mem_dout    = sdata_i[7:0];
               mem_wr      = 1'b1;
               stall_req_o = 1'b1;
               state_nxt   = (in_size == 3'd1) ? DONE : WR;
               cnt_nxt     = 3'd1;
            end else begin
               wreg_o  = wreg_i;
               waddr_o = waddr_i;
               wdata_o = alurslt_i;
            end
         end
         RD: begin
            stall_req_o = 1'b1;
            if (cnt < size) begin
               mem_a   = addr_k;
               cnt_nxt = cnt + 3'd1;
            end else begin
               state_nxt = DONE;
            end
         end
         WR: begin
            stall_req_o = 1'b1;
            mem_a       = addr_k;
            mem_dout    = sbyte;
            mem_wr      = 1'b1;
            if (cnt == size - 3'd1) state_nxt = DONE;
            else                    cnt_nxt   = cnt + 3'd1;
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
            if (is_load(op)) begin
               wreg_o  = wreg;
               waddr_o = waddr;
               wdata_o = ldata_ext;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // reset overrides every output combinationally
      if (rst) begin
         mem_a       = '0;
         mem_dout    = '0;
         mem_wr      = 1'b0;
         stall_req_o = 1'b0;
         wreg_o      = 1'b0;
         waddr_o     = '0;
         wdata_o     = '0;
         misalign_o  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         op    <= '0;
         addr  <= '0;
         sdata <= '0;
         waddr <= '0;
         wreg  <= 1'b0;
         ldata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if ((state == IDLE) && !in_mis && (in_load || in_store)) begin
            op    <= aluop_i;
            addr  <= alurslt_i;
            sdata <= sdata_i;
            waddr <= waddr_i;
            wreg  <= wreg_i;
            ldata <= '0;
         end
         if (state == RD) begin
            case (cnt)
               3'd1:    ldata[7:0]   <= mem_din;
               3'd2:    ldata[15:8]  <= mem_din;
               3'd3:    ldata[23:16] <= mem_din;
               3'd4:    ldata[31:24] <= mem_din;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the pipeline, downstream of the EX/MEM register. It consumes the execute stage's op, address/result, store data and destination fields. Loads and stores run as byte-serial transfers on an 8-bit synchronous RAM port, and non-memory results pass straight through. While a transfer is in progress it raises a stall request toward the staller, and it presents the writeback fields to the MEM/WB register.

## Interface
- ADDR_W, 17, width of mem_a; low bits of the effective address.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- aluop_i  in  `AluOpBus  op from EX/MEM register (`ALU_LB_OP … `ALU_SW_OP, others non-memory).
- wreg_i  in  1  writeback enable from EX/MEM.
- waddr_i  in  5  destination register.
- alurslt_i  in  32  effective address for load/store; result for other ops.
- sdata_i  in  32  store data.
- mem_din  in  8  RAM read data, valid the cycle after its address.
- mem_a  out  ADDR_W  RAM byte address.
- mem_dout  out  8  RAM write data.
- mem_wr  out  1  RAM write strobe, 1 = write this cycle.
- stall_req_o  out  1  hold upstream stages and EX/MEM register.
- wreg_o  out  1  writeback enable to MEM/WB.
- waddr_o  out  5  writeback register.
- wdata_o  out  32  writeback data.
- misalign_o  out  1  misaligned-access flag (see Configuration).

## Operation
- FSM states: IDLE, RD, WR, DONE. Counter cnt[2:0]. Captured registers: op, addr, sdata, waddr, wreg, ldata[31:0].
- Transfer size: B/BU = 1 byte, H/HU = 2 bytes, W = 4 bytes. Little-endian: byte k goes to addr+k. Address arithmetic is 32-bit modulo, then truncated to ADDR_W.
- IDLE, non-memory op: wreg_o/waddr_o/wdata_o = wreg_i/waddr_i/alurslt_i. stall_req_o=0, mem_wr=0.
- IDLE, load:
  - mem_a = alurslt_i, stall_req_o=1. Capture all fields.
  - Go to RD with cnt=1.
- RD:
  - Store mem_din into byte cnt-1 of ldata.
  - If cnt < size, mem_a = addr+cnt and cnt++. Otherwise go to DONE.
  - stall_req_o=1.
- IDLE, store:
  - mem_a = alurslt_i, mem_dout = sdata_i[7:0], mem_wr=1, stall_req_o=1. Capture all fields.
  - If size = 1, go to DONE. Otherwise go to WR with cnt=1.
- WR:
  - mem_a = addr+cnt, mem_dout = sdata byte cnt, mem_wr=1, stall_req_o=1.
  - If cnt = size-1, go to DONE. Otherwise cnt++.
- DONE:
  - stall_req_o=0. Go to IDLE.
  - Load: wreg_o=wreg, waddr_o=waddr, wdata_o = extended ldata. LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend.
  - Store: wreg_o=0.
- Outputs in RD/WR: wreg_o=0, waddr_o=0, wdata_o=0.
- Upstream holds its inputs stable while stall_req_o=1. The op still present in DONE is ignored; the next op is sampled in IDLE.
- rst=1 forces combinationally: mem_wr=0, stall_req_o=0, wreg_o=0, waddr_o=0, wdata_o=0, mem_a=0, mem_dout=0, misalign_o=0.
  - On the clock edge: state=IDLE, cnt=0, captured registers=0.
  - Reset mid-transfer abandons it. Bytes already written stay written.

## Timing
- Load of n bytes: stall_req_o high for cycles 0..n, result in cycle n+1 (LW: 5 stall cycles, result in cycle 5).
- Store of n bytes: writes in cycles 0..n-1, stall high in cycles 0..n-1, DONE in cycle n (SW: 4 writes, DONE in cycle 4).
- Non-memory op: zero latency, no stall.
- Back-to-back memory ops: the second starts in the cycle after DONE.

## Configuration
- MEMACC_MISALIGN_TRAP_EN defined:
  - In IDLE, the access is misaligned if it is H/HU/SH with addr[0]≠0, or W/SW with addr[1:0]≠0.
  - A misaligned access does no memory access and no stall. misalign_o=1 for that cycle, wreg_o=0, state stays IDLE.
- MEMACC_MISALIGN_TRAP_EN undefined: misaligned accesses complete byte-serially as normal. misalign_o tied to 0.

## Test plan
- LW at 0x10, RAM[0x10..0x13]=78,56,34,12 -> stall cycles 0-4, cycle 5: wreg_o=1, wdata_o=0x12345678.
- LB at 0x20 with RAM=0x80 -> wdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x31, sdata=0xAABBCCDD -> writes 0xDD@0x31 then 0xCC@0x32; mem_wr high exactly 2 cycles; wreg_o=0. With MEMACC_MISALIGN_TRAP_EN: no write, misalign_o=1 for 1 cycle.
- ADD result 0x5 to x3 -> same cycle: wreg_o=1, waddr_o=3, wdata_o=5, stall_req_o=0.
- SW to 0xFFFFFFFE with ADDR_W=17 -> bytes land at 0x1FFFE, 0x1FFFF, 0x0, 0x1.
- rst asserted in cycle 2 of an LW -> next cycle: state IDLE, stall_req_o=0, no writeback; a following LB completes normally.
